pipe_if: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipeline. It sits directly upstream of the ID-stage control unit and consumes that unit's stall outputs (IFwip, IDwir) and its next-PC selection (pcsource with branch/jump targets). It drives a handshaked instruction memory and presents IDinst/IDpc4/IDvalid to decode. Taken redirects squash the fetched instruction into a bubble.

---
 rtl/pipe_if.sv | 172 +++++++++++++++++
 tb/tb_pipe_if.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_if.sv
// Instruction-fetch stage with IF/ID pipeline register and handshaked instruction memory.
// Optional build macro IF_STALL_CNT_EN adds the IFstallcnt stall-cycle counter.
module pipe_if #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IFwip,
   input  logic        IDwir,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IFpc,
   output logic [31:0] IDinst,
   output logic [31:0] IDpc4,
   output logic        IDvalid,
   output logic [31:0] IFstallcnt
);

   typedef enum logic [1:0] {
      FETCH = 2'b00,
      WAIT  = 2'b01,
      HOLD  = 2'b10
   } state_t;

   state_t      state_r;
   logic [31:0] pc_r;
   logic [31:0] buf_r;
   logic        discard_r;

   logic        redirect_s;
   logic        advance_s;
   logic        deliver_s;
   logic [31:0] pc4_s;
   logic [31:0] target_s;
   logic [31:0] deliver_inst_s;

   assign pc4_s          = pc_r + 32'd4;
   assign redirect_s     = IDwir & IDvalid & (pcsource != 2'b00);
   assign advance_s      = IFwip & IDwir;
   assign deliver_inst_s = (state_r == HOLD) ? buf_r : imem_rdata;
   // A word reaches IF/ID only from a live (non-discarded) ack or from the hold buffer.
   assign deliver_s      = ~redirect_s & advance_s &
                           (((state_r == WAIT) & imem_ack & ~discard_r) | (state_r == HOLD));
   assign imem_addr      = pc_r;
   assign IFpc           = pc_r;

   // Next-PC target selection for taken redirects
   always_comb begin
      target_s = pc4_s;
      case (pcsource)
         2'b01:   target_s = bpc;
         2'b10:   target_s = rpc;
         2'b11:   target_s = jpc;
         default: target_s = pc4_s;
      endcase
   end

   // Fetch FSM, PC, request handshake, discard flag and hold buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= FETCH;
         pc_r      <= RESET_PC;
         imem_req  <= 1'b0;
         discard_r <= 1'b0;
         buf_r     <= 32'h0000_0000;
      end else if (redirect_s) begin
         pc_r <= target_s;
         case (state_r)
            WAIT: begin
               // Without an ack the request stays up; its late data is dropped via discard.
               if (imem_ack) begin
                  imem_req  <= 1'b0;
                  discard_r <= 1'b0;
                  state_r   <= FETCH;
               end else begin
                  discard_r <= 1'b1;
                  state_r   <= WAIT;
               end
            end
            default: begin
               imem_req <= 1'b0;
               state_r  <= FETCH;
            end
         endcase
      end else begin
         case (state_r)
            FETCH: begin
               imem_req <= 1'b1;
               state_r  <= WAIT;
            end
            WAIT: begin
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  if (discard_r) begin
                     discard_r <= 1'b0;
                     state_r   <= FETCH;
                  end else if (advance_s) begin
                     pc_r    <= pc4_s;
                     state_r <= FETCH;
                  end else begin
                     buf_r   <= imem_rdata;
                     state_r <= HOLD;
                  end
               end else begin
                  state_r <= WAIT;
               end
            end
            HOLD: begin
               if (advance_s) begin
                  pc_r    <= pc4_s;
                  state_r <= FETCH;
               end else begin
                  state_r <= HOLD;
               end
            end
            default: begin
               imem_req <= 1'b0;
               state_r  <= FETCH;
            end
         endcase
      end
   end

   // IF/ID register: redirect bubble, delivery, idle bubble or hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         IDinst  <= NOP_INST;
         IDpc4   <= 32'h0000_0000;
         IDvalid <= 1'b0;
      end else if (redirect_s) begin
         IDinst  <= NOP_INST;
         IDvalid <= 1'b0;
      end else if (deliver_s) begin
         IDinst  <= deliver_inst_s;
         IDpc4   <= pc4_s;
         IDvalid <= 1'b1;
      end else if (IDwir) begin
         IDinst  <= NOP_INST;
         IDvalid <= 1'b0;
      end else begin
         IDinst  <= IDinst;
         IDvalid <= IDvalid;
      end
   end

`ifdef IF_STALL_CNT_EN
   logic [31:0] stallcnt_r;

   // Count cycles in which the PC is held by a load-use stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallcnt_r <= 32'h0000_0000;
      end else if (!IFwip) begin
         stallcnt_r <= stallcnt_r + 32'd1;
      end else begin
         stallcnt_r <= stallcnt_r;
      end
   end

   assign IFstallcnt = stallcnt_r;
`else
   assign IFstallcnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipe_if.sv
// Directed self-checking bench for pipe_if; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pipe_if;

   logic        clk;
   logic        rst;
   logic        IFwip;
   logic        IDwir;
   logic [1:0]  pcsource;
   logic [31:0] bpc;
   logic [31:0] rpc;
   logic [31:0] jpc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] IFpc;
   logic [31:0] IDinst;
   logic [31:0] IDpc4;
   logic        IDvalid;
   logic [31:0] IFstallcnt;

   int tests_run;
   int tests_failed;

   pipe_if #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .IFwip(IFwip), .IDwir(IDwir), .pcsource(pcsource),
      .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IFpc(IFpc), .IDinst(IDinst),
      .IDpc4(IDpc4), .IDvalid(IDvalid), .IFstallcnt(IFstallcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; IFwip = 1'b1; IDwir = 1'b1; pcsource = 2'b00;
      bpc = 32'h0; rpc = 32'h0; jpc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
      step(); step();
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got %h want 0", imem_req); end
      tests_run++; if (IFpc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h want 00000000", IFpc); end
      tests_run++; if (IDvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_idvalid got %h want 0", IDvalid); end
      tests_run++; if (IDinst !== 32'h0) begin tests_failed++; $display("FAIL reset_idinst got %h want 00000000", IDinst); end
      tests_run++; if (IDpc4 !== 32'h0) begin tests_failed++; $display("FAIL reset_idpc4 got %h want 00000000", IDpc4); end
      tests_run++; if (IFstallcnt !== 32'h0) begin tests_failed++; $display("FAIL reset_stallcnt got %h want 00000000", IFstallcnt); end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      step();
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL b2b_req0 got %h want 1", imem_req); end
      tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL b2b_addr0 got %h want 00000000", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h2008_0001;
      step();
      imem_ack = 1'b0;
      tests_run++; if (IDinst !== 32'h2008_0001) begin tests_failed++; $display("FAIL b2b_inst0 got %h want 20080001", IDinst); end
      tests_run++; if (IDpc4 !== 32'h4) begin tests_failed++; $display("FAIL b2b_pc4_0 got %h want 00000004", IDpc4); end
      tests_run++; if (IDvalid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid0 got %h want 1", IDvalid); end
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL b2b_reqdrop got %h want 0", imem_req); end
      step();
      tests_run++; if (imem_addr !== 32'h4) begin tests_failed++; $display("FAIL b2b_addr1 got %h want 00000004", imem_addr); end
      tests_run++; if (IDvalid !== 1'b0) begin tests_failed++; $display("FAIL b2b_bubble got %h want 0", IDvalid); end
      imem_ack = 1'b1; imem_rdata = 32'h2009_0002;
      step();
      imem_ack = 1'b0;
      tests_run++; if (IDinst !== 32'h2009_0002) begin tests_failed++; $display("FAIL b2b_inst1 got %h want 20090002", IDinst); end
      tests_run++; if (IDpc4 !== 32'h8) begin tests_failed++; $display("FAIL b2b_pc4_1 got %h want 00000008", IDpc4); end
   endtask

   task automatic test_hold();
      logic [31:0] exp_cnt;
`ifdef IF_STALL_CNT_EN
      exp_cnt = 32'd3;
`else
      exp_cnt = 32'd0;
`endif
      IFwip = 1'b0; IDwir = 1'b0;
      step();
      tests_run++; if (imem_addr !== 32'h8) begin tests_failed++; $display("FAIL hold_addr got %h want 00000008", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h2010_0003;
      step();
      imem_ack = 1'b0;
      step();
      tests_run++; if (IDinst !== 32'h2009_0002) begin tests_failed++; $display("FAIL hold_inst got %h want 20090002", IDinst); end
      tests_run++; if (IDvalid !== 1'b1) begin tests_failed++; $display("FAIL hold_valid got %h want 1", IDvalid); end
      tests_run++; if (IDpc4 !== 32'h8) begin tests_failed++; $display("FAIL hold_pc4 got %h want 00000008", IDpc4); end
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL hold_req got %h want 0", imem_req); end
      tests_run++; if (IFpc !== 32'h8) begin tests_failed++; $display("FAIL hold_pc got %h want 00000008", IFpc); end
      tests_run++; if (IFstallcnt !== exp_cnt) begin tests_failed++; $display("FAIL hold_stallcnt got %h want %h", IFstallcnt, exp_cnt); end
      IFwip = 1'b1; IDwir = 1'b1;
      step();
      tests_run++; if (IDinst !== 32'h2010_0003) begin tests_failed++; $display("FAIL release_inst got %h want 20100003", IDinst); end
      tests_run++; if (IDpc4 !== 32'hC) begin tests_failed++; $display("FAIL release_pc4 got %h want 0000000c", IDpc4); end
      tests_run++; if (IDvalid !== 1'b1) begin tests_failed++; $display("FAIL release_valid got %h want 1", IDvalid); end
      step();
      tests_run++; if (imem_addr !== 32'hC) begin tests_failed++; $display("FAIL release_addr got %h want 0000000c", imem_addr); end
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL release_req got %h want 1", imem_req); end
   endtask

   task automatic test_branch_discard();
      imem_ack = 1'b1; imem_rdata = 32'h2011_0004;
      step();
      imem_ack = 1'b0; IDwir = 1'b0;
      step();
      tests_run++; if (imem_addr !== 32'h10) begin tests_failed++; $display("FAIL br_addr_pre got %h want 00000010", imem_addr); end
      IDwir = 1'b1; pcsource = 2'b01; bpc = 32'h100;
      step();
      pcsource = 2'b00;
      tests_run++; if (IDvalid !== 1'b0) begin tests_failed++; $display("FAIL br_bubble got %h want 0", IDvalid); end
      tests_run++; if (IFpc !== 32'h100) begin tests_failed++; $display("FAIL br_pc got %h want 00000100", IFpc); end
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL br_req_held got %h want 1", imem_req); end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      tests_run++; if (IDinst !== 32'h0) begin tests_failed++; $display("FAIL br_discard_inst got %h want 00000000", IDinst); end
      tests_run++; if (IDvalid !== 1'b0) begin tests_failed++; $display("FAIL br_discard_valid got %h want 0", IDvalid); end
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL br_discard_req got %h want 0", imem_req); end
      step();
      tests_run++; if (imem_addr !== 32'h100) begin tests_failed++; $display("FAIL br_next_addr got %h want 00000100", imem_addr); end
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL br_next_req got %h want 1", imem_req); end
   endtask

   task automatic test_jr_with_ack();
      imem_ack = 1'b1; imem_rdata = 32'h2012_0005;
      step();
      imem_ack = 1'b0; IDwir = 1'b0;
      tests_run++; if (IDpc4 !== 32'h104) begin tests_failed++; $display("FAIL jr_pre_pc4 got %h want 00000104", IDpc4); end
      step();
      IDwir = 1'b1; pcsource = 2'b10; rpc = 32'h40; imem_ack = 1'b1; imem_rdata = 32'hBADC_0DE0;
      step();
      pcsource = 2'b00; imem_ack = 1'b0;
      tests_run++; if (IDvalid !== 1'b0) begin tests_failed++; $display("FAIL jr_valid got %h want 0", IDvalid); end
      tests_run++; if (IDinst !== 32'h0) begin tests_failed++; $display("FAIL jr_inst got %h want 00000000", IDinst); end
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL jr_req got %h want 0", imem_req); end
      step();
      tests_run++; if (imem_addr !== 32'h40) begin tests_failed++; $display("FAIL jr_next_addr got %h want 00000040", imem_addr); end
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL jr_next_req got %h want 1", imem_req); end
   endtask

   task automatic test_async_reset();
      #2;
      rst = 1'b1;
      #1;
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL areset_req got %h want 0", imem_req); end
      tests_run++; if (IFpc !== 32'h0) begin tests_failed++; $display("FAIL areset_pc got %h want 00000000", IFpc); end
      tests_run++; if (IDpc4 !== 32'h0) begin tests_failed++; $display("FAIL areset_pc4 got %h want 00000000", IDpc4); end
      tests_run++; if (IFstallcnt !== 32'h0) begin tests_failed++; $display("FAIL areset_stallcnt got %h want 00000000", IFstallcnt); end
      step();
      rst = 1'b0;
      step();
      tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL areset_first_addr got %h want 00000000", imem_addr); end
      tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL areset_first_req got %h want 1", imem_req); end
   endtask

   task automatic test_wrap();
      imem_ack = 1'b1; imem_rdata = 32'h0800_0000;
      step();
      imem_ack = 1'b0; IDwir = 1'b0;
      step();
      IDwir = 1'b1; pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
      step();
      pcsource = 2'b00; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      step();
      imem_ack = 1'b0;
      step();
      tests_run++; if (imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h2013_0006;
      step();
      imem_ack = 1'b0;
      tests_run++; if (IDpc4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc4 got %h want 00000000", IDpc4); end
      tests_run++; if (IDinst !== 32'h2013_0006) begin tests_failed++; $display("FAIL wrap_inst got %h want 20130006", IDinst); end
      step();
      tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_next_addr got %h want 00000000", imem_addr); end
   endtask

   task automatic test_stall_cnt();
      logic [31:0] exp_cnt;
`ifdef IF_STALL_CNT_EN
      exp_cnt = 32'd5;
`else
      exp_cnt = 32'd0;
`endif
      IFwip = 1'b0;
      for (int i = 0; i < 5; i++) step();
      IFwip = 1'b1;
      tests_run++; if (IFstallcnt !== exp_cnt) begin tests_failed++; $display("FAIL stallcnt got %h want %h", IFstallcnt, exp_cnt); end
      tests_run++; if (IFpc !== 32'h0) begin tests_failed++; $display("FAIL stall_pc got %h want 00000000", IFpc); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_back_to_back();
      test_hold();
      test_branch_discard();
      test_jr_with_ack();
      test_async_reset();
      test_wrap();
      test_stall_cnt();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
